cache_data_stage: RTL and testbench

- Data-array stage directly downstream of TLB lookup. Consumes the tag block's data-array commands (petitionToData, lineIdData, writeEnableData) plus the forwarded instruction fields.
- Performs line fills, byte/word loads and byte/word stores on a num_cache_lines x cache_line_width array.
- Supplies the evicted line to the memory arbiter.
- Registers the result into the CACHE/WB pipeline register, whose outputs also drive the CACHE bypass path back to TLB lookup.

---
 rtl/cache_data_stage_pkg.sv | 27 ++
 rtl/cache_data_array.sv | 50 +++++
 rtl/cache_data_stage.sv | 109 ++++++++++
 tb/tb_cache_data_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_stage_pkg.sv
// Shared types and encodings for the cache data stage.
// Line/offset widths, ldSt and bypass encodings, CACHE/WB bundle.
package cache_data_stage_pkg;

   localparam int LINE_ID_W = 2;
   localparam int OFFSET_W  = 5;

   localparam logic [1:0] LDST_NONE = 2'b00;
   localparam logic [1:0] LDST_ST   = 2'b01;
   localparam logic [1:0] LDST_LD   = 2'b10;

   typedef enum logic [1:0] {
      BP_NONE = 2'd0,
      BP_ALU  = 2'd1,
      BP_MEM  = 2'd2,
      BP_RSV  = 2'd3
   } bp_e;

   // 22-bit CACHE/WB pipeline register contents
   typedef struct packed {
      logic [15:0] result;
      logic [2:0]  dest;
      logic        we;
      bp_e         bp;
   } cache_wb_t;

endpackage

// File: rtl/cache_data_array.sv
// Cache data array: line storage, fill port, byte/word write merge.
// Single read port shared by loads and eviction.
module cache_data_array
   import cache_data_stage_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int WORD_W = 16,
   parameter int BYTE_W = 8,
   parameter int LINES  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fill_i,
   input  logic                 wr_en_i,
   input  logic                 word_i,
   input  logic [LINE_ID_W-1:0] line_id_i,
   input  logic [OFFSET_W-1:0]  offset_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [LINE_W-1:0]    fill_line_i,
   output logic [LINE_W-1:0]    rd_line_o
);

   localparam int IDX_W = $clog2(LINE_W);

   logic [LINE_W-1:0] mem_q [LINES];
   logic [IDX_W-1:0]  byte_idx;
   logic [IDX_W-1:0]  word_idx;

   assign byte_idx  = {offset_i, 3'b000};
   assign word_idx  = {offset_i[OFFSET_W-1:1], 4'b0000};
   assign rd_line_o = mem_q[line_id_i];

   // Storage update: reset clears, fill beats a processor store
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (fill_i) begin
         mem_q[line_id_i] <= fill_line_i;
      end else if (wr_en_i) begin
         if (word_i) begin
            mem_q[line_id_i][word_idx +: WORD_W] <= wdata_i;
         end else begin
            mem_q[line_id_i][byte_idx +: BYTE_W] <= wdata_i[BYTE_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cache_data_stage.sv
// Cache data stage: drives the data array, selects load/ALU result,
// and registers it into CACHE/WB (also the bypass source).
module cache_data_stage
   import cache_data_stage_pkg::*;
#(
   parameter int cache_line_width = 256,
   parameter int word_width       = 16,
   parameter int byte_width       = 8,
   parameter int addr_width       = 16,
   parameter int num_cache_lines  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable_cache,
   input  logic [addr_width-1:0]       address,
   input  logic [word_width-1:0]       dataReg,
   input  logic [1:0]                  ldSt_enable,
   input  logic                        wordAccess,
   input  logic [2:0]                  destReg_addr_input,
   input  logic                        we_input,
   input  logic [1:0]                  bp_input,
   input  logic                        petitionToData,
   input  logic [LINE_ID_W-1:0]        lineIdData,
   input  logic                        writeEnableData,
   input  logic [cache_line_width-1:0] memLineIn,
   output logic [cache_line_width-1:0] lineToMem,
   output logic [word_width-1:0]       cache_result,
   output logic [2:0]                  destReg_addrCACHE,
   output logic                        we_output,
   output logic [1:0]                  bp_from_cache
);

   localparam int IDX_W = $clog2(cache_line_width);

   logic                        fill;
   logic                        proc_acc;
   logic                        st_en;
   logic                        ld_sel;
   logic [cache_line_width-1:0] rd_line;
   logic [IDX_W-1:0]            byte_idx;
   logic [IDX_W-1:0]            word_idx;
   logic [byte_width-1:0]       ld_byte;
   logic [word_width-1:0]       ld_word;
   logic [word_width-1:0]       result;
   cache_wb_t                   wb_d;
   cache_wb_t                   wb_q;

   assign fill     = petitionToData & writeEnableData;
   assign proc_acc = petitionToData & ~writeEnableData;
   // stalled stores are held off so they commit exactly once
   assign st_en    = proc_acc & (ldSt_enable == LDST_ST) & enable_cache;
   assign ld_sel   = proc_acc & (ldSt_enable == LDST_LD);

   cache_data_array #(
      .LINE_W (cache_line_width),
      .WORD_W (word_width),
      .BYTE_W (byte_width),
      .LINES  (num_cache_lines)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .fill_i      (fill),
      .wr_en_i     (st_en),
      .word_i      (wordAccess),
      .line_id_i   (lineIdData),
      .offset_i    (address[OFFSET_W-1:0]),
      .wdata_i     (dataReg),
      .fill_line_i (memLineIn),
      .rd_line_o   (rd_line)
   );

   assign lineToMem = rd_line;
   assign byte_idx  = {address[OFFSET_W-1:0], 3'b000};
   assign word_idx  = {address[OFFSET_W-1:1], 4'b0000};
   assign ld_byte   = rd_line[byte_idx +: byte_width];
   assign ld_word   = rd_line[word_idx +: word_width];

   // Result select: load data or ALU passthrough
   always_comb begin
      result = address;
      if (ld_sel) begin
         if (wordAccess) begin
            result = ld_word;
         end else begin
            result = {{(word_width-byte_width){1'b0}}, ld_byte};
         end
      end
   end

   assign wb_d.result = result;
   assign wb_d.dest   = destReg_addr_input;
   assign wb_d.we     = we_input;
   assign wb_d.bp     = bp_e'(bp_input);

   // CACHE/WB pipeline register, held while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_q <= '0;
      end else if (enable_cache) begin
         wb_q <= wb_d;
      end
   end

   assign cache_result      = wb_q.result;
   assign destReg_addrCACHE = wb_q.dest;
   assign we_output         = wb_q.we;
   assign bp_from_cache     = wb_q.bp;

endmodule

// File: tb/tb_cache_data_stage.sv
// Directed self-checking bench for cache_data_stage.
// Keeps a shadow copy of the array to check eviction data.
module tb_cache_data_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable_cache;
   logic [15:0]  address;
   logic [15:0]  dataReg;
   logic [1:0]   ldSt_enable;
   logic         wordAccess;
   logic [2:0]   destReg_addr_input;
   logic         we_input;
   logic [1:0]   bp_input;
   logic         petitionToData;
   logic [1:0]   lineIdData;
   logic         writeEnableData;
   logic [255:0] memLineIn;
   logic [255:0] lineToMem;
   logic [15:0]  cache_result;
   logic [2:0]   destReg_addrCACHE;
   logic         we_output;
   logic [1:0]   bp_from_cache;

   int n_checks = 0;
   int n_fail   = 0;

   logic [255:0] exp_line [4];
   logic [255:0] pat;

   cache_data_stage dut (
      .clk                (clk),
      .reset              (reset),
      .enable_cache       (enable_cache),
      .address            (address),
      .dataReg            (dataReg),
      .ldSt_enable        (ldSt_enable),
      .wordAccess         (wordAccess),
      .destReg_addr_input (destReg_addr_input),
      .we_input           (we_input),
      .bp_input           (bp_input),
      .petitionToData     (petitionToData),
      .lineIdData         (lineIdData),
      .writeEnableData    (writeEnableData),
      .memLineIn          (memLineIn),
      .lineToMem          (lineToMem),
      .cache_result       (cache_result),
      .destReg_addrCACHE  (destReg_addrCACHE),
      .we_output          (we_output),
      .bp_from_cache      (bp_from_cache)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset              = 1'b0;
      enable_cache       = 1'b1;
      address            = 16'h0000;
      dataReg            = 16'h0000;
      ldSt_enable        = 2'b00;
      wordAccess         = 1'b0;
      destReg_addr_input = 3'd0;
      we_input           = 1'b0;
      bp_input           = 2'd0;
      petitionToData     = 1'b0;
      lineIdData         = 2'd0;
      writeEnableData    = 1'b0;
      memLineIn          = '0;
   endtask

   task automatic do_fill(input logic [1:0] id, input logic [255:0] d,
                          input logic [15:0] a);
      idle();
      petitionToData  = 1'b1;
      writeEnableData = 1'b1;
      lineIdData      = id;
      memLineIn       = d;
      address         = a;
      tick();
      exp_line[id] = d;
   endtask

   task automatic do_load(input logic [1:0] id, input logic [15:0] a,
                          input logic w);
      idle();
      petitionToData = 1'b1;
      ldSt_enable    = 2'b10;
      lineIdData     = id;
      address        = a;
      wordAccess     = w;
      tick();
   endtask

   task automatic do_store(input logic [1:0] id, input logic [15:0] a,
                           input logic w, input logic [15:0] d);
      idle();
      petitionToData = 1'b1;
      ldSt_enable    = 2'b01;
      lineIdData     = id;
      address        = a;
      wordAccess     = w;
      dataReg        = d;
      tick();
      if (w) exp_line[id][{a[4:1], 4'b0} +: 16] = d;
      else   exp_line[id][{a[4:0], 3'b0} +: 8]  = d[7:0];
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) exp_line[i] = '0;
      n_checks++;
      if ({cache_result, destReg_addrCACHE, we_output, bp_from_cache} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_regs got=%h exp=0",
                  {cache_result, destReg_addrCACHE, we_output, bp_from_cache});
      end
      for (int i = 0; i < 4; i++) begin
         lineIdData = 2'(i);
         #1;
         n_checks++;
         if (lineToMem !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_line%0d got=%h exp=0", i, lineToMem);
         end
      end
   endtask

   task automatic test_fill_load();
      for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
      do_fill(2'd1, pat, 16'h0ABC);
      n_checks++;
      if (cache_result !== 16'h0ABC) begin
         n_fail++;
         $display("FAIL fill_result got=%h exp=0abc", cache_result);
      end
      do_load(2'd1, 16'h0025, 1'b0);
      n_checks++;
      if (cache_result !== 16'h0005) begin
         n_fail++;
         $display("FAIL byte_load got=%h exp=0005", cache_result);
      end
      do_load(2'd1, 16'h0026, 1'b1);
      n_checks++;
      if (cache_result !== 16'h0706) begin
         n_fail++;
         $display("FAIL word_load got=%h exp=0706", cache_result);
      end
      do_load(2'd1, 16'h0027, 1'b1);
      n_checks++;
      if (cache_result !== 16'h0706) begin
         n_fail++;
         $display("FAIL word_load_odd got=%h exp=0706", cache_result);
      end
      do_load(2'd1, 16'h003F, 1'b0);
      n_checks++;
      if (cache_result !== 16'h001F) begin
         n_fail++;
         $display("FAIL byte_load_top got=%h exp=001f", cache_result);
      end
      idle();
      petitionToData = 1'b0;
      ldSt_enable    = 2'b10;
      lineIdData     = 2'd1;
      address        = 16'h0025;
      tick();
      n_checks++;
      if (cache_result !== 16'h0025) begin
         n_fail++;
         $display("FAIL miss_load got=%h exp=0025", cache_result);
      end
   endtask

   task automatic test_word_store();
      do_store(2'd2, 16'h0044, 1'b1, 16'hBEEF);
      do_load(2'd2, 16'h0044, 1'b1);
      n_checks++;
      if (cache_result !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL wst_word got=%h exp=beef", cache_result);
      end
      do_load(2'd2, 16'h0044, 1'b0);
      n_checks++;
      if (cache_result !== 16'h00EF) begin
         n_fail++;
         $display("FAIL wst_lo got=%h exp=00ef", cache_result);
      end
      do_load(2'd2, 16'h0045, 1'b0);
      n_checks++;
      if (cache_result !== 16'h00BE) begin
         n_fail++;
         $display("FAIL wst_hi got=%h exp=00be", cache_result);
      end
   endtask

   task automatic test_byte_store_evict();
      pat = {8{32'hA5C3_0F69}};
      do_fill(2'd3, pat, 16'h0000);
      do_store(2'd3, 16'h001F, 1'b0, 16'hFF12);
      idle();
      lineIdData = 2'd3;
      #1;
      n_checks++;
      if (lineToMem !== exp_line[3]) begin
         n_fail++;
         $display("FAIL bst_evict got=%h exp=%h", lineToMem, exp_line[3]);
      end
      idle();
      petitionToData  = 1'b1;
      writeEnableData = 1'b1;
      ldSt_enable     = 2'b01;
      dataReg         = 16'hFFFF;
      lineIdData      = 2'd3;
      memLineIn       = {16{16'h3C3C}};
      #1;
      n_checks++;
      if (lineToMem !== exp_line[3]) begin
         n_fail++;
         $display("FAIL evict_preedge got=%h exp=%h", lineToMem, exp_line[3]);
      end
      tick();
      exp_line[3] = {16{16'h3C3C}};
      idle();
      lineIdData = 2'd3;
      #1;
      n_checks++;
      if (lineToMem !== exp_line[3]) begin
         n_fail++;
         $display("FAIL fill_wins got=%h exp=%h", lineToMem, exp_line[3]);
      end
   endtask

   task automatic test_stall_store();
      idle();
      address            = 16'h7777;
      destReg_addr_input = 3'd3;
      we_input           = 1'b1;
      bp_input           = 2'd2;
      tick();
      idle();
      petitionToData = 1'b1;
      ldSt_enable    = 2'b01;
      lineIdData     = 2'd0;
      address        = 16'h0003;
      dataReg        = 16'h005A;
      enable_cache   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if ({cache_result, destReg_addrCACHE, we_output, bp_from_cache}
             !== {16'h7777, 3'd3, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL stall_hold%0d got=%h/%0d/%0d/%0d exp=7777/3/1/2", c,
                     cache_result, destReg_addrCACHE, we_output, bp_from_cache);
         end
         n_checks++;
         if (lineToMem !== exp_line[0]) begin
            n_fail++;
            $display("FAIL stall_nowrite%0d got=%h exp=%h", c, lineToMem, exp_line[0]);
         end
      end
      enable_cache = 1'b1;
      tick();
      exp_line[0][24 +: 8] = 8'h5A;
      n_checks++;
      if (cache_result !== 16'h0003) begin
         n_fail++;
         $display("FAIL stall_release got=%h exp=0003", cache_result);
      end
      do_load(2'd0, 16'h0003, 1'b0);
      n_checks++;
      if (cache_result !== 16'h005A) begin
         n_fail++;
         $display("FAIL stall_load got=%h exp=005a", cache_result);
      end
      do_load(2'd0, 16'h0002, 1'b1);
      n_checks++;
      if (cache_result !== 16'h5A00) begin
         n_fail++;
         $display("FAIL stall_word got=%h exp=5a00", cache_result);
      end
   endtask

   task automatic test_passthrough();
      idle();
      petitionToData     = 1'b1;
      address            = 16'h1234;
      we_input           = 1'b1;
      bp_input           = 2'd1;
      destReg_addr_input = 3'd5;
      dataReg            = 16'hDEAD;
      tick();
      n_checks++;
      if ({cache_result, destReg_addrCACHE, we_output, bp_from_cache}
          !== {16'h1234, 3'd5, 1'b1, 2'd1}) begin
         n_fail++;
         $display("FAIL passthru got=%h/%0d/%0d/%0d exp=1234/5/1/1",
                  cache_result, destReg_addrCACHE, we_output, bp_from_cache);
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         lineIdData = 2'(i);
         #1;
         n_checks++;
         if (lineToMem !== exp_line[i]) begin
            n_fail++;
            $display("FAIL passthru_line%0d got=%h exp=%h", i, lineToMem, exp_line[i]);
         end
      end
   endtask

   task automatic test_reset_clear();
      for (int i = 0; i < 4; i++) do_fill(2'(i), {32{8'(8'h11 * (i + 1))}}, 16'h4321);
      idle();
      enable_cache       = 1'b0;
      tick();
      idle();
      reset              = 1'b1;
      enable_cache       = 1'b1;
      petitionToData     = 1'b1;
      writeEnableData    = 1'b1;
      memLineIn          = {8{32'hFFFF_FFFF}};
      address            = 16'h9999;
      we_input           = 1'b1;
      bp_input           = 2'd3;
      destReg_addr_input = 3'd7;
      tick();
      for (int i = 0; i < 4; i++) exp_line[i] = '0;
      idle();
      #1;
      n_checks++;
      if ({cache_result, destReg_addrCACHE, we_output, bp_from_cache} !== 22'd0) begin
         n_fail++;
         $display("FAIL rst_regs got=%h exp=0",
                  {cache_result, destReg_addrCACHE, we_output, bp_from_cache});
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         lineIdData = 2'(i);
         #1;
         n_checks++;
         if (lineToMem !== 256'd0) begin
            n_fail++;
            $display("FAIL rst_line%0d got=%h exp=0", i, lineToMem);
         end
         do_load(2'(i), 16'h0011, 1'b1);
         n_checks++;
         if (cache_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_load%0d got=%h exp=0000", i, cache_result);
         end
      end
      idle();
      address      = 16'h5555;
      we_input     = 1'b1;
      tick();
      idle();
      enable_cache = 1'b0;
      reset        = 1'b1;
      tick();
      n_checks++;
      if ({cache_result, we_output} !== 17'd0) begin
         n_fail++;
         $display("FAIL rst_stall got=%h/%0d exp=0/0", cache_result, we_output);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fill_load();
      test_word_store();
      test_byte_store_evict();
      test_stall_store();
      test_passthrough();
      test_reset_clear();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
